// File: rtl/sdram_bus_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter and neighbouring bus blocks.
// Holds the grant-state encoding, the default error read data and the request bundle.
package sdram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Per-transaction watchdog: counts stalled grant cycles, pulses expire_o on the last
// allowed cycle and keeps a sticky error flag until reset.
module sdram_arb_watchdog
    import sdram_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o,
    output logic timeout_err_o
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count_q, count_d;
    logic          err_q;

    // A ready in the expiry cycle wins, so expiry needs ready_i low.
    assign expire_o = (TIMEOUT_CYCLES != 0) && active_i && !ready_i && (count_q == LAST);

    // NOTE: count_d gets its default before any condition so no latch is inferred.
    always_comb begin
        count_d = '0;
        if (active_i && !ready_i && !expire_o) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (expire_o) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = err_q;

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Two-master arbiter in front of the single SDRAM controller port, with round-robin or
// fixed priority, a one-cycle bubble between transactions and a watchdog for stalls.
module sdram_bus_arbiter
    import sdram_bus_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        timeout_err,
    output logic        grant_id
);

    arb_state_e state_q, state_d;
    logic       last_winner_q, last_winner_d;
    logic       grant_id_q, grant_id_d;
    bus_req_t   req0, req1, req_sel;
    logic       in_grant, sel, expire;

    assign req0     = '{valid: m0_valid, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign req1     = '{valid: m1_valid, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    assign in_grant = (state_q != IDLE);
    assign sel      = (state_q == GNT1);
    assign req_sel  = sel ? req1 : req0;

    sdram_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .active_i     (in_grant && req_sel.valid),
        .ready_i      (s_ready),
        .expire_o     (expire),
        .timeout_err_o(timeout_err)
    );

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        grant_id_d    = grant_id_q;
        s_valid       = 1'b0;
        s_addr        = '0;
        s_wdata       = '0;
        s_wstrb       = '0;
        m0_ready      = 1'b0;
        m0_rdata      = '0;
        m1_ready      = 1'b0;
        m1_rdata      = '0;
        case (state_q)
            IDLE: begin
                // On a tie m0 wins if priority is fixed or m1 won last time.
                if (m0_valid && (!m1_valid || FIXED_PRIORITY || last_winner_q)) begin
                    state_d    = GNT0;
                    grant_id_d = 1'b0;
                end else if (m1_valid) begin
                    state_d    = GNT1;
                    grant_id_d = 1'b1;
                end
            end
            GNT0, GNT1: begin
                s_valid = req_sel.valid && !expire;
                s_addr  = req_sel.addr;
                s_wdata = req_sel.wdata;
                s_wstrb = req_sel.wstrb;
                if (s_ready || expire) begin
                    if (sel) begin
                        m1_ready = 1'b1;
                        m1_rdata = s_ready ? s_rdata : ERR_RDATA;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = s_ready ? s_rdata : ERR_RDATA;
                    end
                    last_winner_d = sel;
                    state_d       = IDLE;
                end else if (!req_sel.valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            grant_id_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign grant_id = grant_id_q;

endmodule
